// File: rtl/clz_seq_if.sv
// ============================================================================
//  Module      : clz_seq_if
//  Description : Operand-in / result-out handshake bundle for clz_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clz_seq_if #(
  parameter int WIDTH = 64
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_zero, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_zero, busy
  );
endinterface

`default_nettype wire

// File: rtl/clz_seq.sv
// ============================================================================
//  Module      : clz_seq
//  Description : Iterative leading-zero counter, one CHUNK-bit slice per cycle
//                from the MSB end. Optional macro CLZ_SEQ_EARLY_EXIT_EN ends
//                the scan on the first nonzero chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clz_seq_chunk_clz #(
  parameter int CHUNK = 16,
  parameter int PW    = $clog2(CHUNK)
) (
  input  wire logic [CHUNK-1:0] din,
  output logic      [PW-1:0]    pout,
  output logic                  valid
);
  // Later (higher) set bits override earlier ones, leaving the MSB-most hit.
  always_comb begin
    pout = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (din[i]) pout = PW'(CHUNK - 1 - i);
    end
  end

  assign valid = |din;
endmodule

module clz_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input wire logic clk,
  input wire logic rst_n,
  clz_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(WIDTH) + 1;
  localparam int PW     = $clog2(CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [CW-1:0]    r_out_count;
  logic             r_out_zero;

  logic [CHUNK-1:0] w_chunk;
  logic [PW-1:0]    w_pout;
  logic             w_cvalid;
  logic             w_hit;
  logic             w_found_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_last;
  logic             w_exit;

  assign w_chunk = r_sr[WIDTH-1 -: CHUNK];

  clz_seq_chunk_clz #(
    .CHUNK (CHUNK),
    .PW    (PW)
  ) u_clz (
    .din   (w_chunk),
    .pout  (w_pout),
    .valid (w_cvalid)
  );

  // Only the first nonzero chunk contributes; idx*CHUNK is a plain shift.
  assign w_hit        = !r_found && w_cvalid;
  assign w_found_next = r_found || w_cvalid;
  assign w_cnt_next   = w_hit ? ((CW'(r_idx) << PW) + CW'(w_pout)) : r_cnt;
  assign w_last       = (r_idx == IW'(NCHUNK - 1));

`ifdef CLZ_SEQ_EARLY_EXIT_EN
  assign w_exit = w_last || w_hit;
`else
  assign w_exit = w_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_idx       <= '0;
      r_found     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sr    <= bus.in_data;
            r_idx   <= '0;
            r_found <= 1'b0;
            r_cnt   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          r_sr    <= r_sr << CHUNK;
          r_idx   <= r_idx + IW'(1);
          r_found <= w_found_next;
          r_cnt   <= w_cnt_next;
          if (w_exit) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_zero  <= !w_found_next;
            r_out_count <= w_found_next ? w_cnt_next : CW'(WIDTH);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_count = r_out_count;
  assign bus.out_zero  = r_out_zero;
endmodule

`default_nettype wire

// File: tb/tb_clz_seq.sv
// ============================================================================
//  Module      : tb_clz_seq
//  Description : Self-checking bench for clz_seq against a bit-scan model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clz_seq;
  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   hs_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clz_seq_if #(.WIDTH(WIDTH)) bus ();

  clz_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int ref_clz(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) if (d[i]) return 63 - i;
    return 64;
  endfunction

  function automatic int ref_lat(input logic [63:0] d);
`ifdef CLZ_SEQ_EARLY_EXIT_EN
    int c;
    c = ref_clz(d);
    return (c == WIDTH) ? NCHUNK : (c / CHUNK) + 1;
`else
    return NCHUNK + 0 * d[0];
`endif
  endfunction

  // Offer one operand, wait (bounded) for the result; leaves DONE pending.
  task automatic run_op(input logic [63:0] d, output int lat, output int cnt, output bit zero);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    hs_cyc       = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom(), $urandom()};
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    cnt  = int'(bus.out_count);
    zero = bus.out_zero;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_count !== 7'd0) $display("FAIL rst_out_count got=%0d exp=0", bus.out_count); else n_pass++;
    n_checks++; if (bus.out_zero !== 1'b0) $display("FAIL rst_out_zero got=%b exp=0", bus.out_zero); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_directed();
    logic [63:0] vec [4];
    int lat, cnt;
    bit zero;
    vec[0] = 64'h8000_0000_0000_0000;
    vec[1] = 64'h0;
    vec[2] = 64'h0000_0000_0001_0000;
    vec[3] = 64'h1;
    for (int k = 0; k < 4; k++) begin
      run_op(vec[k], lat, cnt, zero);
      n_checks++; if (cnt !== ref_clz(vec[k])) $display("FAIL dir_count[%0d] got=%0d exp=%0d", k, cnt, ref_clz(vec[k])); else n_pass++;
      n_checks++; if (zero !== (vec[k] == 0)) $display("FAIL dir_zero[%0d] got=%b exp=%b", k, zero, vec[k] == 0); else n_pass++;
      n_checks++; if (lat !== ref_lat(vec[k])) $display("FAIL dir_latency[%0d] got=%0d exp=%0d", k, lat, ref_lat(vec[k])); else n_pass++;
      ack();
      n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        $display("FAIL dir_return_idle[%0d] got in_ready=%b out_valid=%b exp 1/0", k, bus.in_ready, bus.out_valid); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    int lat, cnt;
    bit zero;
    d = 64'h0000_00F0_0000_0000;
    run_op(d, lat, cnt, zero);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin bus.in_valid = 1'b1; bus.in_data = 64'h1; end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_count !== 7'd24 || bus.out_zero !== 1'b0 || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b c=%0d z=%b rdy=%b exp 1/24/0/0", k, bus.out_valid, bus.out_count, bus.out_zero, bus.in_ready);
      else n_pass++;
    end
    ack();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_accept_next got=%b exp=1", bus.in_ready); else n_pass++;
    d = 64'h0000_0000_0000_0300;
    run_op(d, lat, cnt, zero);
    n_checks++; if (cnt !== 54 || zero !== 1'b0) $display("FAIL bp_next_count got=%0d/%b exp=54/0", cnt, zero); else n_pass++;
    ack();
  endtask

  task automatic test_reset_mid_scan();
    logic [63:0] d;
    int lat, cnt, seen;
    bit zero;
    run_op(64'h0000_0000_0001_0000, lat, cnt, zero);
    ack();
    bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_00FF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL scan_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_count !== 7'd0 || bus.out_zero !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL async_rst got v=%b c=%0d z=%b busy=%b rdy=%b exp 0/0/0/0/1", bus.out_valid, bus.out_count, bus.out_zero, bus.busy, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); else n_pass++;
    seen = 0;
    for (int k = 0; k < NCHUNK + 4; k++) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    n_checks++; if (seen !== 0) $display("FAIL aborted_out_valid got=%0d cycles exp=0", seen); else n_pass++;
    d = 64'h0040_0000_0000_0000;
    run_op(d, lat, cnt, zero);
    n_checks++; if (cnt !== ref_clz(d)) $display("FAIL post_abort_count got=%0d exp=%0d", cnt, ref_clz(d)); else n_pass++;
    ack();
  endtask

  task automatic test_random();
    logic [63:0] d;
    int lat, cnt;
    bit zero;
    for (int k = 0; k < 24; k++) begin
      d = {$urandom(), $urandom()} >> $urandom_range(0, 64);
      run_op(d, lat, cnt, zero);
      n_checks++; if (cnt !== ref_clz(d) || zero !== (d == 0) || lat !== ref_lat(d))
        $display("FAIL rand[%0d] d=%h got cnt=%0d z=%b lat=%0d exp cnt=%0d z=%b lat=%0d", k, d, cnt, zero, lat, ref_clz(d), d == 0, ref_lat(d));
      else n_pass++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    int lat, cnt, prev_hs, prev_lat;
    bit zero;
    prev_hs = 0; prev_lat = 0;
    for (int k = 0; k < 4; k++) begin
      d = {$urandom(), $urandom()} >> (16 * k);
      run_op(d, lat, cnt, zero);
      n_checks++; if (cnt !== ref_clz(d)) $display("FAIL b2b_count[%0d] got=%0d exp=%0d", k, cnt, ref_clz(d)); else n_pass++;
      if (k > 0) begin
        n_checks++; if (hs_cyc - prev_hs !== prev_lat + 2)
          $display("FAIL b2b_period[%0d] got=%0d exp=%0d", k, hs_cyc - prev_hs, prev_lat + 2);
        else n_pass++;
      end
      prev_hs  = hs_cyc;
      prev_lat = ref_lat(d);
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
